// File: rtl/data_sram_control.sv
// Asynchronous SRAM controller for the memory stage: one load or store per request,
// fixed strobe timing set by RD_CYCLES / WE_CYCLES, registered strobes and load data.
module data_sram_control #(
    parameter int RD_CYCLES = 2,
    parameter int WE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [19:0] ramAddr_i,
    input  logic [31:0] storeData_i,
    input  logic [3:0]  byteSel_i,
    output logic [31:0] loadData_o,
    output logic        ready_o,
    output logic        stall_o,
    output logic        CE_n_o,
    output logic        OE_n_o,
    output logic        WE_n_o,
    output logic [3:0]  be_n_o,
    output logic [19:0] ramAddr_o,
    inout  wire  [31:0] data_io
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_e;

    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] wdata_q;
    logic [31:0] load_q;
    logic [19:0] addr_q;
    logic [3:0]  be_n_q;
    logic        drive_q;
    logic        ready_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;

    // Every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            addr_q  <= '0;
            be_n_q  <= '1;
            drive_q <= 1'b0;
            ready_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= ramAddr_i;
                        wdata_q <= storeData_i;
                        ce_n_q  <= 1'b0;
                        if (we_i) begin
                            state_q <= WR_SETUP;
                            cnt_q   <= '0;
                            be_n_q  <= ~byteSel_i;
                            drive_q <= 1'b1;
                        end else begin
                            state_q <= RD;
                            cnt_q   <= RD_LAST;
                            be_n_q  <= '0;
                            oe_n_q  <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (cnt_q == '0) begin
                        load_q  <= data_io;
                        state_q <= DONE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        be_n_q  <= '1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    cnt_q   <= WE_LAST;
                    we_n_q  <= 1'b0;
                end
                WR_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= WR_HOLD;
                        cnt_q   <= '0;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_HOLD: begin
                    state_q <= DONE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    ce_n_q  <= 1'b1;
                    be_n_q  <= '1;
                    drive_q <= 1'b0;
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_io    = drive_q ? wdata_q : 'z;
    assign loadData_o = load_q;
    assign ready_o    = ready_q;
    assign CE_n_o     = ce_n_q;
    assign OE_n_o     = oe_n_q;
    assign WE_n_o     = we_n_q;
    assign be_n_o     = be_n_q;
    assign ramAddr_o  = addr_q;

    assign stall_o = rst_n && (((state_q == IDLE) && req_i) ||
                               ((state_q != IDLE) && (state_q != DONE)));

endmodule

// File: tb/tb_data_sram_control.sv
// Directed bench for data_sram_control with a small byte-lane SRAM model on data_io.
module tb_data_sram_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [19:0] ramAddr_i;
    logic [31:0] storeData_i;
    logic [3:0]  byteSel_i;
    logic [31:0] loadData_o;
    logic        ready_o;
    logic        stall_o;
    logic        CE_n_o;
    logic        OE_n_o;
    logic        WE_n_o;
    logic [3:0]  be_n_o;
    logic [19:0] ramAddr_o;
    wire  [31:0] data_io;

    int ncmp  = 0;
    int nfail = 0;

    data_sram_control #(
        .RD_CYCLES(2),
        .WE_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .ramAddr_i  (ramAddr_i),
        .storeData_i(storeData_i),
        .byteSel_i  (byteSel_i),
        .loadData_o (loadData_o),
        .ready_o    (ready_o),
        .stall_o    (stall_o),
        .CE_n_o     (CE_n_o),
        .OE_n_o     (OE_n_o),
        .WE_n_o     (WE_n_o),
        .be_n_o     (be_n_o),
        .ramAddr_o  (ramAddr_o),
        .data_io    (data_io)
    );

    always #5 clk = ~clk;

    // SRAM model: 256 words indexed by the low address byte; contents restored on reset.
    logic [31:0] mem [0:255];
    assign data_io = (!CE_n_o && !OE_n_o) ? mem[ramAddr_o[7:0]] : 'z;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h23] <= 32'hDEADBEEF;
            mem[8'h40] <= 32'h11223344;
            mem[8'h60] <= 32'hCAFEF00D;
        end else if (!CE_n_o && !WE_n_o) begin
            for (int k = 0; k < 4; k++)
                if (!be_n_o[k]) mem[ramAddr_o[7:0]][k*8 +: 8] <= data_io[k*8 +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // An undriven bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
    task automatic chk_free(input string name);
        ncmp++;
        if (!((data_io === 32'hzzzzzzzz) || (data_io === 32'h0))) begin
            nfail++;
            $display("FAIL %s: bus driven with %h expected high-Z", name, data_io);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access from the accept cycle (cycle 0) through ready_o and back to IDLE.
    task automatic access(input logic we, input logic [19:0] a, input logic [31:0] d,
                          input logic [3:0] bs, input logic [31:0] exp_ld,
                          input int exp_lat, input logic [3:0] exp_ben);
        int lat = 0;
        int oe_cnt = 0;
        int we_cnt = 0;
        req_i = 1'b1; we_i = we; ramAddr_i = a; storeData_i = d; byteSel_i = bs;
        #1;
        chk("stall_accept", 32'(stall_o), 32'd1);
        for (int n = 1; n <= 30 && lat == 0; n++) begin
            step();
            if (n == 1) req_i = 1'b0;
            if (ready_o) begin
                lat = n;
                chk("stall_done", 32'(stall_o), 32'd0);
                chk("load_data", loadData_o, exp_ld);
                chk("strobes_done", {29'd0, CE_n_o, OE_n_o, WE_n_o}, 32'h7);
                chk("be_done", 32'(be_n_o), 32'hF);
                chk_free("bus_done");
            end else begin
                if (!OE_n_o) oe_cnt++;
                if (!WE_n_o) we_cnt++;
                chk("stall_busy", 32'(stall_o), 32'd1);
                chk("ce_busy", 32'(CE_n_o), 32'd0);
                chk("addr_busy", 32'(ramAddr_o), 32'(a));
                chk("be_busy", 32'(be_n_o), 32'(exp_ben));
                if (we) begin
                    chk("oe_on_write", 32'(OE_n_o), 32'd1);
                    chk("wdata_busy", data_io, d);
                end
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("oe_cycles", 32'(oe_cnt), we ? 32'd0 : 32'd2);
        chk("we_cycles", 32'(we_cnt), we ? 32'd2 : 32'd0);
        step();
        chk("ready_pulse_end", 32'(ready_o), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [31:0] data;
        logic [3:0]  bsel;
        logic [31:0] exp_ld;
        int          exp_lat;
        logic [3:0]  exp_ben;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 20'h00123, 32'h0,        4'h0, 32'hDEADBEEF, 3, 4'h0};
        vecs[1] = '{1'b1, 20'h00040, 32'h000000AA, 4'h1, 32'hDEADBEEF, 5, 4'hE};
        vecs[2] = '{1'b0, 20'h00040, 32'h0,        4'h0, 32'h112233AA, 3, 4'h0};
        vecs[3] = '{1'b1, 20'h00060, 32'hFFFFFFFF, 4'h0, 32'h112233AA, 5, 4'hF};
        vecs[4] = '{1'b0, 20'h00060, 32'h0,        4'h0, 32'hCAFEF00D, 3, 4'h0};
        vecs[5] = '{1'b1, 20'h00123, 32'h00005500, 4'h2, 32'hCAFEF00D, 5, 4'hD};
        vecs[6] = '{1'b0, 20'h00123, 32'h0,        4'h0, 32'hDEAD55EF, 3, 4'h0};
        vecs[7] = '{1'b1, 20'h00040, 32'hA5000000, 4'h8, 32'hDEAD55EF, 5, 4'h7};
        vecs[8] = '{1'b0, 20'h00040, 32'h0,        4'h0, 32'hA52233AA, 3, 4'h0};

        rst_n = 1'b0; req_i = 1'b1; we_i = 1'b0;
        ramAddr_i = 20'h00123; storeData_i = 32'h0; byteSel_i = 4'h0;
        step();
        step();
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_strobes", {29'd0, CE_n_o, OE_n_o, WE_n_o}, 32'h7);
        chk("rst_be", 32'(be_n_o), 32'hF);
        chk("rst_addr", 32'(ramAddr_o), 32'h0);
        chk("rst_load", loadData_o, 32'h0);
        chk_free("rst_bus");
        req_i = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_stall", 32'(stall_o), 32'd0);

        for (int i = 0; i < 9; i++)
            access(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].bsel,
                   vecs[i].exp_ld, vecs[i].exp_lat, vecs[i].exp_ben);

        // Store then a load held on req_i: the load is taken in the IDLE cycle after DONE.
        req_i = 1'b1; we_i = 1'b1; ramAddr_i = 20'h00060; storeData_i = 32'h000000EE; byteSel_i = 4'h1;
        step();
        we_i = 1'b0;
        for (int n = 2; n <= 5; n++) step();
        chk("b2b_store_ready", 32'(ready_o), 32'd1);
        step();
        chk("b2b_idle_ready", 32'(ready_o), 32'd0);
        chk("b2b_idle_oe", 32'(OE_n_o), 32'd1);
        chk("b2b_idle_stall", 32'(stall_o), 32'd1);
        chk_free("b2b_idle_bus");
        step();
        req_i = 1'b0;
        chk("b2b_rd_oe", 32'(OE_n_o), 32'd0);
        step();
        chk("b2b_rd2_oe", 32'(OE_n_o), 32'd0);
        step();
        chk("b2b_load_ready", 32'(ready_o), 32'd1);
        chk("b2b_load_data", loadData_o, 32'hCAFEF0EE);
        step();

        // Input churn after acceptance must not reach the SRAM side.
        begin
            int lat = 0;
            req_i = 1'b1; we_i = 1'b1; ramAddr_i = 20'h00040; storeData_i = 32'h00770000; byteSel_i = 4'h4;
            for (int n = 1; n <= 20 && lat == 0; n++) begin
                step();
                req_i = 1'b0;
                ramAddr_i = 20'($urandom);
                storeData_i = $urandom;
                byteSel_i = 4'($urandom);
                we_i = 1'($urandom);
                if (ready_o) lat = n;
                else begin
                    chk("churn_addr", 32'(ramAddr_o), 32'h00040);
                    chk("churn_data", data_io, 32'h00770000);
                    chk("churn_be", 32'(be_n_o), 32'hB);
                end
            end
            chk("churn_latency", 32'(lat), 32'd5);
            step();
        end
        access(1'b0, 20'h00040, 32'h0, 4'h0, 32'hA57733AA, 3, 4'h0);

        // Reset while WE_n_o is low aborts the store with no ready pulse.
        req_i = 1'b1; we_i = 1'b1; ramAddr_i = 20'h00060; storeData_i = 32'h12345678; byteSel_i = 4'hF;
        step();
        req_i = 1'b0;
        step();
        chk("abort_we_low", 32'(WE_n_o), 32'd0);
        rst_n = 1'b0;
        step();
        chk("abort_we", 32'(WE_n_o), 32'd1);
        chk("abort_ce", 32'(CE_n_o), 32'd1);
        chk("abort_ready", 32'(ready_o), 32'd0);
        chk("abort_stall", 32'(stall_o), 32'd0);
        chk("abort_addr", 32'(ramAddr_o), 32'h0);
        chk("abort_load", loadData_o, 32'h0);
        chk_free("abort_bus");
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("abort_no_ready", 32'(ready_o), 32'd0);
            chk("abort_idle_stall", 32'(stall_o), 32'd0);
        end
        access(1'b0, 20'h00060, 32'h0, 4'h0, 32'hCAFEF00D, 3, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
